hdmi_i2c_target: RTL and testbench

// I2C target (responder) exposing an 8-bit-subaddressed byte register space to an external I2C controller.

---
 rtl/hdmi_i2c_target.sv | 252 +++++++++++++++++++++++++
 tb/tb_hdmi_i2c_target.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_i2c_target.sv
// hdmi_i2c_target: I2C target exposing an 8-bit subaddressed register space.
// Bus traffic is turned into single-cycle register strobes on iCLK.
// Ports:
//   iCLK, iRST_N        system clock, async active-low reset
//   I2C_SCL, I2C_SDA    bus clock in, open-drain data (drives 0 or z only)
//   REG_ADDR            register pointer
//   REG_WDATA, REG_WE   write data and 1-cycle write strobe
//   REG_RE, REG_RDATA   1-cycle read request, data sampled 2 cycles later
//   BUSY                addressed transaction in progress
module hdmi_i2c_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h39,
  parameter int unsigned FILT       = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  output logic       REG_RE,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  localparam int unsigned FCW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int unsigned BCW = 4;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, W_ACK, RDATA, R_ACK, IGNORE
  } state_t;

  logic [1:0]     scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic           scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic           scl_p_q, scl_p_d, sda_p_q, sda_p_d;
  logic [FCW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           rw_q, rw_d;
  logic           sda_oe_q, sda_oe_d;
  logic [7:0]     reg_addr_q, reg_addr_d;
  logic [7:0]     reg_wdata_q, reg_wdata_d;
  logic           reg_we_q, reg_we_d;
  logic           reg_re_q, reg_re_d;
  logic           busy_q, busy_d;
  logic [1:0]     rd_pipe_q, rd_pipe_d;

  logic       scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0] byte_in;

  assign I2C_SDA   = sda_oe_q ? 1'b0 : 1'bz;
  assign REG_ADDR  = reg_addr_q;
  assign REG_WDATA = reg_wdata_q;
  assign REG_WE    = reg_we_q;
  assign REG_RE    = reg_re_q;
  assign BUSY      = busy_q;

  // Synchronizers and glitch filters: a level changes only after FILT
  // consecutive samples disagree with it.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], I2C_SCL};
    sda_sync_d = {sda_sync_q[0], I2C_SDA};
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    scl_cnt_d  = '0;
    sda_cnt_d  = '0;
    scl_p_d    = scl_f_q;
    sda_p_d    = sda_f_q;
    if (scl_sync_q[1] != scl_f_q) begin
      if (scl_cnt_q == FCW'(FILT - 1)) scl_f_d = scl_sync_q[1];
      else                             scl_cnt_d = scl_cnt_q + FCW'(1);
    end
    if (sda_sync_q[1] != sda_f_q) begin
      if (sda_cnt_q == FCW'(FILT - 1)) sda_f_d = sda_sync_q[1];
      else                             sda_cnt_d = sda_cnt_q + FCW'(1);
    end
  end

  assign scl_rise   = scl_f_q & ~scl_p_q;
  assign scl_fall   = ~scl_f_q & scl_p_q;
  assign start_cond = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_cond  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign byte_in    = {shift_q[6:0], sda_f_q};

  // Protocol FSM: bits counted on SCL rise, ACK/data driven from SCL fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    rd_pipe_d   = {rd_pipe_q[0], reg_re_q};

    // Pointer advances the cycle after a write strobe.
    if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;

    if (stop_cond) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_cond) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bit_cnt_q == BCW'(7)) begin
              if (byte_in[7:1] != SLAVE_ADDR) begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end else begin
                busy_d = 1'b1;
                rw_d   = byte_in[0];
              end
            end
          end else if (scl_fall && bit_cnt_q == BCW'(8)) begin
            state_d  = ADDR_ACK;
            sda_oe_d = 1'b1;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (rw_q) begin
              reg_re_d = 1'b1;
              state_d  = RDATA;
            end else begin
              state_d = SUB;
            end
          end
        end
        SUB, WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bit_cnt_q == BCW'(7)) begin
              if (state_q == SUB) begin
                reg_addr_d = byte_in;
              end else begin
                reg_wdata_d = byte_in;
                reg_we_d    = 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt_q == BCW'(8)) begin
            state_d  = (state_q == SUB) ? SUB_ACK : W_ACK;
            sda_oe_d = 1'b1;
          end
        end
        SUB_ACK, W_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WDATA;
          end
        end
        RDATA: begin
          // Host data arrives two cycles after the request; MSB goes out at once.
          if (rd_pipe_q[1]) begin
            shift_d  = REG_RDATA;
            sda_oe_d = ~REG_RDATA[7];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end else if (scl_fall) begin
            if (bit_cnt_q == BCW'(8)) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = R_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        R_ACK: begin
          // bit_cnt marks a received controller ACK until the closing SCL fall.
          if (scl_rise) begin
            if (!sda_f_q) begin
              reg_addr_d = reg_addr_q + 8'd1;
              bit_cnt_d  = BCW'(1);
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && bit_cnt_q == BCW'(1)) begin
            reg_re_d  = 1'b1;
            bit_cnt_d = '0;
            state_d   = RDATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      scl_f_q     <= 1'b1;
      sda_f_q     <= 1'b1;
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      scl_cnt_q   <= '0;
      sda_cnt_q   <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_f_q     <= scl_f_d;
      sda_f_q     <= sda_f_d;
      scl_p_q     <= scl_p_d;
      sda_p_q     <= sda_p_d;
      scl_cnt_q   <= scl_cnt_d;
      sda_cnt_q   <= sda_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

endmodule

// File: tb/tb_hdmi_i2c_target.sv
// tb_hdmi_i2c_target: directed bench for hdmi_i2c_target.
// Acts as I2C controller plus host register file; expected register
// strobes are queued before each byte and matched when the DUT strobes.
module tb_hdmi_i2c_target;

  localparam int Q = 100;  // quarter SCL period (10 iCLK cycles)

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } we_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       ctrl_sda_low = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, host_rdata;
  logic       reg_we, reg_re, busy;

  logic [7:0] mem [256];
  we_t        exp_we [$];
  logic [7:0] exp_re [$];

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;
  int   drv_seen = 0;
  int   busy_seen = 0;

  pullup (sda_bus);
  assign sda_bus = ctrl_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  hdmi_i2c_target dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .I2C_SCL  (scl),
    .I2C_SDA  (sda_bus),
    .REG_ADDR (reg_addr),
    .REG_WDATA(reg_wdata),
    .REG_WE   (reg_we),
    .REG_RE   (reg_re),
    .REG_RDATA(host_rdata),
    .BUSY     (busy)
  );

  // Host register file: returns data one cycle after the request and holds it.
  always @(posedge clk) if (reg_re) host_rdata <= mem[reg_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && (reg_we || reg_re)) begin
      check("we_re_exclusive", {31'd0, reg_we & reg_re}, 32'd0);
      if (reg_we) begin
        check("we_expected", {31'd0, exp_we.size() != 0}, 32'd1);
        if (exp_we.size() != 0) begin
          we_t e;
          e = exp_we.pop_front();
          check("we_addr", {24'd0, reg_addr}, {24'd0, e.addr});
          check("we_data", {24'd0, reg_wdata}, {24'd0, e.data});
        end
      end
      if (reg_re) begin
        check("re_expected", {31'd0, exp_re.size() != 0}, 32'd1);
        if (exp_re.size() != 0) begin
          logic [7:0] a;
          a = exp_re.pop_front();
          check("re_addr", {24'd0, reg_addr}, {24'd0, a});
        end
      end
    end
  end

  // Target-drive and BUSY watch used while the target must stay silent.
  always @(posedge clk) begin
    if (mon_en && !ctrl_sda_low && sda_bus === 1'b0) drv_seen++;
    if (mon_en && busy) busy_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bit slot; glitch 1 pulses SCL while low, glitch 2 pulses SDA while SCL high.
  task automatic bit_xfer(input logic drv_low, input int glitch, output logic smp);
    ctrl_sda_low = drv_low;
    if (glitch == 1) begin #(Q/2); scl = 1'b1; #10; scl = 1'b0; #(Q/2-10); end
    else #Q;
    scl = 1'b1;
    if (glitch == 2) begin
      #(Q/2); ctrl_sda_low = !drv_low; #10; ctrl_sda_low = drv_low; #(Q/2-10);
    end else #Q;
    smp = sda_bus;
    #Q; scl = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] b, input int g_scl, input int g_sda, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--)
      bit_xfer(!b[i], (i == g_scl) ? 1 : ((i == g_sda) ? 2 : 0), s);
    bit_xfer(1'b0, 0, ack);
  endtask

  task automatic wchk(input logic [7:0] b, input logic exp_ack, input string tag);
    logic a;
    wbyte(b, -1, -1, a);
    check(tag, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic rbyte(input logic give_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b0, 0, s);
      d[i] = s;
    end
    bit_xfer(give_ack, 0, s);
  endtask

  task automatic i2c_start();
    ctrl_sda_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    ctrl_sda_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    ctrl_sda_low = 1'b1; #Q;
    scl = 1'b1; #Q;
    ctrl_sda_low = 1'b0; #(2*Q);
  endtask

  initial begin
    logic [7:0] d;
    logic       a;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h96);
    mem[8'h20] = 8'h5A;
    mem[8'h21] = 8'hC3;
    mem[8'h40] = 8'h3C;
    host_rdata = 8'h00;

    // Reset state
    #(Q);
    check("rst_addr", {24'd0, reg_addr}, 32'h00);
    check("rst_wdata", {24'd0, reg_wdata}, 32'h00);
    check("rst_we", {31'd0, reg_we}, 32'd0);
    check("rst_re", {31'd0, reg_re}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sda", {31'd0, sda_bus}, 32'd1);
    rst_n = 1'b1;
    #(2*Q);

    // Multi-byte write with auto-increment
    i2c_start();
    wchk(8'h72, 1'b0, "w1_addr_ack");
    check("w1_busy", {31'd0, busy}, 32'd1);
    wchk(8'h10, 1'b0, "w1_sub_ack");
    exp_we.push_back('{addr: 8'h10, data: 8'hAB});
    wchk(8'hAB, 1'b0, "w1_d0_ack");
    exp_we.push_back('{addr: 8'h11, data: 8'hCD});
    wchk(8'hCD, 1'b0, "w1_d1_ack");
    i2c_stop();
    check("w1_busy_stop", {31'd0, busy}, 32'd0);
    check("w1_we_drained", exp_we.size(), 32'd0);
    check("w1_ptr", {24'd0, reg_addr}, 32'h12);

    // Subaddressed read with repeated START, ACK then NACK
    i2c_start();
    wchk(8'h72, 1'b0, "r1_addr_ack");
    wchk(8'h20, 1'b0, "r1_sub_ack");
    i2c_start();
    exp_re.push_back(8'h20);
    wchk(8'h73, 1'b0, "r1_raddr_ack");
    exp_re.push_back(8'h21);
    rbyte(1'b1, d);
    check("r1_byte0", {24'd0, d}, 32'h5A);
    rbyte(1'b0, d);
    check("r1_byte1", {24'd0, d}, 32'hC3);
    i2c_stop();
    check("r1_busy_stop", {31'd0, busy}, 32'd0);
    check("r1_re_drained", exp_re.size(), 32'd0);

    // Foreign address: no ACK, no drive, no strobes, no BUSY
    mon_en = 1'b1;
    i2c_start();
    wchk(8'h74, 1'b1, "x_addr_nack");
    wchk(8'h10, 1'b1, "x_b0_nack");
    wchk(8'h55, 1'b1, "x_b1_nack");
    wchk(8'h00, 1'b1, "x_b2_nack");
    i2c_stop();
    mon_en = 1'b0;
    check("x_sda_never_driven", drv_seen, 32'd0);
    check("x_busy_never", busy_seen, 32'd0);

    // Pointer wrap FF -> 00
    i2c_start();
    wchk(8'h72, 1'b0, "wr_addr_ack");
    wchk(8'hFF, 1'b0, "wr_sub_ack");
    exp_we.push_back('{addr: 8'hFF, data: 8'h11});
    wchk(8'h11, 1'b0, "wr_d0_ack");
    exp_we.push_back('{addr: 8'h00, data: 8'h22});
    wchk(8'h22, 1'b0, "wr_d1_ack");
    i2c_stop();
    check("wr_we_drained", exp_we.size(), 32'd0);
    check("wr_ptr", {24'd0, reg_addr}, 32'h01);

    // Single-cycle glitches on SCL and SDA inside a data byte
    i2c_start();
    wchk(8'h72, 1'b0, "g_addr_ack");
    wchk(8'h30, 1'b0, "g_sub_ack");
    exp_we.push_back('{addr: 8'h30, data: 8'h96});
    wbyte(8'h96, 5, 2, a);
    check("g_data_ack", {31'd0, a}, 32'd0);
    exp_we.push_back('{addr: 8'h31, data: 8'h69});
    wbyte(8'h69, 6, 3, a);
    check("g_data2_ack", {31'd0, a}, 32'd0);
    i2c_stop();
    check("g_we_drained", exp_we.size(), 32'd0);

    // Reset while the target drives read data
    i2c_start();
    wchk(8'h72, 1'b0, "rr_addr_ack");
    wchk(8'h40, 1'b0, "rr_sub_ack");
    i2c_start();
    exp_re.push_back(8'h40);
    wchk(8'h73, 1'b0, "rr_raddr_ack");
    #(Q/2);
    check("rr_msb_driven", {31'd0, sda_bus}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rr_sda_released", {31'd0, sda_bus}, 32'd1);
    check("rr_busy", {31'd0, busy}, 32'd0);
    check("rr_ptr", {24'd0, reg_addr}, 32'h00);
    check("rr_re_drained", exp_re.size(), 32'd0);
    scl = 1'b1;
    ctrl_sda_low = 1'b0;
    #(Q);
    rst_n = 1'b1;
    #(2*Q);
    i2c_start();
    wchk(8'h72, 1'b0, "rr2_addr_ack");
    wchk(8'h05, 1'b0, "rr2_sub_ack");
    exp_we.push_back('{addr: 8'h05, data: 8'hEE});
    wchk(8'hEE, 1'b0, "rr2_d0_ack");
    i2c_stop();
    check("rr2_we_drained", exp_we.size(), 32'd0);
    check("rr2_ptr", {24'd0, reg_addr}, 32'h06);

    #(Q);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
